// File: rtl/hazard_ctrl_if.sv
// Hazard-detection inputs and pipeline hold/nop controls shared between the
// datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       D_rs1_i;
  logic [4:0]       D_rs2_i;
  logic             D_use_rs1_i;
  logic             D_use_rs2_i;
  logic             DD_load_i;
  logic [4:0]       DD_dstE_i;
  logic             E_mispredict_i;
  logic             E_md_start_i;
  logic             md_done_i;
  logic             M_dmem_wait_i;

  logic             PC_stall_o;
  logic             F_stall_o;
  logic             F_bubble_o;
  logic             D_stall_o;
  logic             D_bubble_o;
  logic             E_stall_o;
  logic             E_bubble_o;
  logic             md_busy_o;
  logic             md_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, DD_load_i, DD_dstE_i,
           E_mispredict_i, E_md_start_i, md_done_i, M_dmem_wait_i,
    input  PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
           E_stall_o, E_bubble_o, md_busy_o, md_timeout_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  D_rs1_i, D_rs2_i, D_use_rs1_i, D_use_rs2_i, DD_load_i, DD_dstE_i,
           E_mispredict_i, E_md_start_i, md_done_i, M_dmem_wait_i,
    output PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o,
           E_stall_o, E_bubble_o, md_busy_o, md_timeout_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stall, mul/div busy with watchdog,
// mispredict flush and load-use stall. Define HAZ_PERF_CNT_EN to build the
// stall/flush performance counters; otherwise they read as zero.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic         clk_i,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int BUSY_W = $clog2(MD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              timeout_q, timeout_d;

  logic load_use;
  logic pc_stall, f_stall, f_bubble, d_stall, d_bubble, e_stall, e_bubble;

  // A load result is not forwardable in time to a reader sitting in decode.
  always_comb begin
    load_use = hz.DD_load_i && (hz.DD_dstE_i != 5'd0) &&
               ((hz.D_use_rs1_i && (hz.D_rs1_i == hz.DD_dstE_i)) ||
                (hz.D_use_rs2_i && (hz.D_rs2_i == hz.DD_dstE_i)));
  end

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    pc_stall   = 1'b0;
    f_stall    = 1'b0;
    f_bubble   = 1'b0;
    d_stall    = 1'b0;
    d_bubble   = 1'b0;
    e_stall    = 1'b0;
    e_bubble   = 1'b0;

    if (hz.M_dmem_wait_i) begin
      pc_stall = 1'b1;
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
    end else begin
      case (state_q)
        MD_BUSY: begin
          if (hz.md_done_i) begin
            busy_cnt_d = '0;
            if (hz.E_mispredict_i) begin
              f_bubble = 1'b1;
              d_bubble = 1'b1;
              state_d  = FLUSH;
            end else begin
              state_d  = RUN;
            end
          end else begin
            pc_stall = 1'b1;
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            e_bubble = 1'b1;
            // The counter already includes the issue cycle, so it reaches
            // the limit on the MD_TIMEOUT-th cycle spent in MD_BUSY.
            if (busy_cnt_q >= BUSY_W'(MD_TIMEOUT)) begin
              timeout_d  = 1'b1;
              busy_cnt_d = '0;
              state_d    = RUN;
            end else begin
              busy_cnt_d = busy_cnt_q + BUSY_W'(1);
            end
          end
        end

        FLUSH: begin
          f_bubble = 1'b1;
          state_d  = RUN;
        end

        default: begin
          if (hz.E_md_start_i && !hz.md_done_i) begin
            pc_stall   = 1'b1;
            f_stall    = 1'b1;
            d_stall    = 1'b1;
            e_bubble   = 1'b1;
            busy_cnt_d = BUSY_W'(1);
            state_d    = MD_BUSY;
          end else if (hz.E_mispredict_i) begin
            f_bubble = 1'b1;
            d_bubble = 1'b1;
            state_d  = FLUSH;
          end else if (load_use) begin
            pc_stall = 1'b1;
            f_stall  = 1'b1;
            d_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Controls are forced low while reset is held, even with live inputs.
  assign hz.PC_stall_o   = rst_n & pc_stall;
  assign hz.F_stall_o    = rst_n & f_stall;
  assign hz.F_bubble_o   = rst_n & f_bubble;
  assign hz.D_stall_o    = rst_n & d_stall;
  assign hz.D_bubble_o   = rst_n & d_bubble;
  assign hz.E_stall_o    = rst_n & e_stall;
  assign hz.E_bubble_o   = rst_n & e_bubble;
  assign hz.md_busy_o    = (state_q == MD_BUSY);
  assign hz.md_timeout_o = timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
    flush_cnt_d = flush_cnt_q + CNT_W'((state_d == FLUSH) && (state_q != FLUSH));
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
`else
  assign hz.stall_cnt_o = '0;
  assign hz.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  // Reference model: a mul/div is outstanding (with its age in busy cycles),
  // or a one-cycle flush follows a redirect; outputs follow the priority rules.
  bit          m_busy, m_flushing, m_timeout;
  int          m_md_age;
  logic [31:0] m_stalls, m_flushes;
  bit          n_busy, n_flushing, n_timeout, n_flush_entry;
  int          n_md_age;
  bit          x_pc, x_fs, x_fb, x_ds, x_db, x_es, x_eb;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic ld,
                               input logic [4:0] dst, input logic mp, input logic mds,
                               input logic mdd, input logic dw);
    vectors++;
    hz.D_rs1_i        = rs1;
    hz.D_rs2_i        = rs2;
    hz.D_use_rs1_i    = u1;
    hz.D_use_rs2_i    = u2;
    hz.DD_load_i      = ld;
    hz.DD_dstE_i      = dst;
    hz.E_mispredict_i = mp;
    hz.E_md_start_i   = mds;
    hz.md_done_i      = mdd;
    hz.M_dmem_wait_i  = dw;
    #2;
  endtask

  task automatic quiet();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetModel();
    m_busy = 0; m_flushing = 0; m_timeout = 0; m_md_age = 0;
    m_stalls = '0; m_flushes = '0;
  endtask

  task automatic modelEval();
    bit hazard;
    hazard = hz.DD_load_i && hz.DD_dstE_i != 0 &&
             ((hz.D_use_rs1_i && hz.D_rs1_i == hz.DD_dstE_i) ||
              (hz.D_use_rs2_i && hz.D_rs2_i == hz.DD_dstE_i));
    {x_pc, x_fs, x_fb, x_ds, x_db, x_es, x_eb} = '0;
    if (!rst_n) resetModel();
    n_busy = m_busy; n_flushing = m_flushing; n_timeout = m_timeout;
    n_md_age = m_md_age; n_flush_entry = 0;
    if (!rst_n) begin
      // everything held at zero
    end else if (hz.M_dmem_wait_i) begin
      {x_pc, x_fs, x_ds, x_es} = 4'b1111;
    end else if (m_busy) begin
      if (hz.md_done_i) begin
        n_busy = 0; n_md_age = 0;
        if (hz.E_mispredict_i) begin
          x_fb = 1; x_db = 1; n_flushing = 1; n_flush_entry = 1;
        end
      end else begin
        {x_pc, x_fs, x_ds, x_eb} = 4'b1111;
        n_md_age = m_md_age + 1;
        if (n_md_age == MD_TIMEOUT) begin
          n_timeout = 1; n_busy = 0; n_md_age = 0;
        end
      end
    end else if (m_flushing) begin
      x_fb = 1; n_flushing = 0;
    end else if (hz.E_md_start_i && !hz.md_done_i) begin
      {x_pc, x_fs, x_ds, x_eb} = 4'b1111;
      n_busy = 1; n_md_age = 0;
    end else if (hz.E_mispredict_i) begin
      x_fb = 1; x_db = 1; n_flushing = 1; n_flush_entry = 1;
    end else if (hazard) begin
      x_pc = 1; x_fs = 1; x_db = 1;
    end
  endtask

  task automatic advanceClock();
    modelEval();
    checkOutput("PC_stall", hz.PC_stall_o, x_pc);
    checkOutput("F_stall", hz.F_stall_o, x_fs);
    checkOutput("F_bubble", hz.F_bubble_o, x_fb);
    checkOutput("D_stall", hz.D_stall_o, x_ds);
    checkOutput("D_bubble", hz.D_bubble_o, x_db);
    checkOutput("E_stall", hz.E_stall_o, x_es);
    checkOutput("E_bubble", hz.E_bubble_o, x_eb);
    checkOutput("md_busy", hz.md_busy_o, m_busy);
    checkOutput("md_timeout", hz.md_timeout_o, m_timeout);
    checkOutput("stall_cnt", hz.stall_cnt_o, PERF ? m_stalls : 32'd0);
    checkOutput("flush_cnt", hz.flush_cnt_o, PERF ? m_flushes : 32'd0);
    checkOutput("F_excl", hz.F_stall_o & hz.F_bubble_o, 1'b0);
    checkOutput("D_excl", hz.D_stall_o & hz.D_bubble_o, 1'b0);
    checkOutput("E_excl", hz.E_stall_o & hz.E_bubble_o, 1'b0);
    @(posedge clk);
    m_stalls   = m_stalls + 32'(x_pc);
    m_flushes  = m_flushes + 32'(n_flush_entry);
    m_busy     = n_busy;
    m_flushing = n_flushing;
    m_timeout  = n_timeout;
    m_md_age   = n_md_age;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {hz.PC_stall_o, hz.F_stall_o, hz.F_bubble_o, hz.D_stall_o,
                                hz.D_bubble_o, hz.E_stall_o, hz.E_bubble_o}, 7'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    quiet();
    advanceClock();
    quiet();
    advanceClock();
    rst_n = 1'b1;
  endtask

  initial begin
    int busy;
    resetModel();
    $display("[TB] start, perf counters %0s", PERF ? "enabled" : "disabled");

    // Reset with live hazard inputs: controls and state must read zero.
    rst_n = 1'b0;
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    checkAllZero("reset");
    checkOutput("reset_busy", hz.md_busy_o, 1'b0);
    checkOutput("reset_tmo", hz.md_timeout_o, 1'b0);
    checkOutput("reset_cnt", {hz.stall_cnt_o, hz.flush_cnt_o}, 64'd0);
    advanceClock();
    doReset();

    // Load-use on rs1, then on rs2, and the non-hazard variants.
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_ctl", {hz.PC_stall_o, hz.F_stall_o, hz.D_bubble_o, hz.D_stall_o, hz.E_bubble_o}, 5'b11100);
    advanceClock();
    quiet();
    checkOutput("lu_one_cycle", hz.PC_stall_o, 1'b0);
    advanceClock();
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_r0", hz.PC_stall_o, 1'b0);
    advanceClock();
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2", {hz.PC_stall_o, hz.F_stall_o, hz.D_bubble_o}, 3'b111);
    advanceClock();
    applyStimulus(5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_rs2_unused", hz.PC_stall_o, 1'b0);
    advanceClock();

    // Mispredict: two bubbles, then fetch-only bubble ignoring a load-use.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("mp_c0", {hz.F_bubble_o, hz.D_bubble_o, hz.F_stall_o}, 3'b110);
    advanceClock();
    applyStimulus(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mp_c1", {hz.F_bubble_o, hz.D_bubble_o, hz.PC_stall_o}, 3'b100);
    advanceClock();
    quiet();
    checkAllZero("mp_c2");
    checkOutput("mp_flush_cnt", hz.flush_cnt_o, PERF ? 32'd1 : 32'd0);
    advanceClock();

    // Divide finishing ten cycles after issue.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("div_issue", {hz.PC_stall_o, hz.F_stall_o, hz.D_stall_o, hz.E_bubble_o, hz.md_busy_o}, 5'b11110);
    advanceClock();
    busy = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (hz.md_busy_o) busy++;
      checkOutput("div_ebub", hz.E_bubble_o, 1'b1);
      advanceClock();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    if (hz.md_busy_o) busy++;
    checkAllZero("div_done");
    advanceClock();
    quiet();
    checkOutput("div_busy_cycles", busy, 10);
    checkOutput("div_idle", hz.md_busy_o, 1'b0);
    checkOutput("div_stall_cnt", hz.stall_cnt_o, PERF ? 32'd10 : 32'd0);
    advanceClock();

    // Start and done together: no stall at all.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkAllZero("div_zero");
    advanceClock();
    quiet();
    checkOutput("div_zero_idle", hz.md_busy_o, 1'b0);
    advanceClock();

    // Memory wait outranks a busy divider and a load-use hazard.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    advanceClock();
    quiet(); advanceClock();
    quiet(); advanceClock();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("prio_ctl", {hz.PC_stall_o, hz.F_stall_o, hz.D_stall_o, hz.E_stall_o,
                               hz.F_bubble_o, hz.D_bubble_o, hz.E_bubble_o}, 7'b1111000);
      checkOutput("prio_hold", hz.md_busy_o, 1'b1);
      advanceClock();
    end
    quiet();
    checkOutput("prio_resume", {hz.md_busy_o, hz.E_bubble_o, hz.E_stall_o}, 3'b110);
    advanceClock();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    advanceClock();

    // Watchdog: done never arrives.
    doReset();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    advanceClock();
    busy = 0;
    quiet();
    while (hz.md_busy_o && busy < 200) begin
      busy++;
      advanceClock();
      quiet();
    end
    checkOutput("wd_cycles", busy, MD_TIMEOUT);
    checkOutput("wd_flag", {hz.md_timeout_o, hz.md_busy_o}, 2'b10);
    advanceClock();
    quiet(); advanceClock();
    quiet();
    checkOutput("wd_sticky", hz.md_timeout_o, 1'b1);
    advanceClock();

    // Reset in the middle of a divide.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    advanceClock();
    quiet(); advanceClock();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    checkOutput("rst_mid_state", {hz.md_busy_o, hz.md_timeout_o}, 2'b00);
    advanceClock();
    quiet(); advanceClock();
    rst_n = 1'b1;
    quiet();
    checkAllZero("rst_after");
    checkOutput("rst_after_busy", hz.md_busy_o, 1'b0);
    advanceClock();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) < 3),
                    ($urandom_range(0, 19) < 2), ($urandom_range(0, 9) == 0));
      advanceClock();
    end
    rst_n = 1'b1;

    $display("[TB] %0d checks made", checks);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_TIMEOUT, default 64: maximum number of MD_BUSY cycles before the watchdog fires.
REQ-002 Parameter CNT_W, default 32: width of each performance counter.
REQ-003 Port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Ports D_rs1_i and D_rs2_i, input, 5 each: source registers of the instruction in decode.
REQ-006 Ports D_use_rs1_i and D_use_rs2_i, input, 1 each: the decode instruction reads rs1 / rs2.
REQ-007 Port DD_load_i, input, 1: the instruction in execute is a load.
REQ-008 Port DD_dstE_i, input, 5: destination register of the execute instruction.
REQ-009 Port E_mispredict_i, input, 1: execute resolved a misprediction; held while execute is stalled.
REQ-010 Port E_md_start_i, input, 1: execute holds a multi-cycle mul/div operation.
REQ-011 Port md_done_i, input, 1: the mul/div unit result is valid this cycle.
REQ-012 Port M_dmem_wait_i, input, 1: memory stage is waiting on data memory.
REQ-013 Ports PC_stall_o, F_stall_o, F_bubble_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o, output, 1 each: hold or nop-insert controls for the PC, fetch, decode and execute pipeline registers.
REQ-014 Port md_busy_o, output, 1: FSM is in MD_BUSY.
REQ-015 Port md_timeout_o, output, 1: sticky watchdog flag.
REQ-016 Ports stall_cnt_o and flush_cnt_o, output, CNT_W each: performance counters (see Configuration).

Function
REQ-017 FSM states SHALL be RUN, MD_BUSY and FLUSH; all control outputs SHALL be combinational from the current state and inputs.
REQ-018 Priority SHALL be, highest first: M_dmem_wait_i, then MD_BUSY, then mispredict/FLUSH, then load-use.
REQ-019 When M_dmem_wait_i=1: PC_stall, F_stall, D_stall and E_stall SHALL be 1, all bubbles SHALL be 0, and the FSM SHALL hold its state.
REQ-020 Load-use hazard: DD_load_i=1 and DD_dstE_i!=0 and a used source register equals DD_dstE_i.
REQ-021 On a load-use hazard: PC_stall=1, F_stall=1, D_bubble=1; lasts exactly one cycle.
REQ-022 RUN with E_mispredict_i=1: F_bubble=1 and D_bubble=1; next state FLUSH.
REQ-023 FLUSH: F_bubble=1 for one cycle; next state RUN. A load-use hazard SHALL be ignored in FLUSH.
REQ-024 RUN with E_md_start_i=1 and md_done_i=0: PC_stall, F_stall and D_stall SHALL be 1, E_bubble=1; next state MD_BUSY; the busy counter loads 1.
REQ-025 MD_BUSY with md_done_i=0: same outputs as REQ-024; the busy counter increments.
REQ-026 MD_BUSY with md_done_i=1: all control outputs 0 and return to RUN; a mispredict present that same cycle SHALL be handled per REQ-022.
REQ-027 Busy counter reaching MD_TIMEOUT: md_timeout_o SHALL be set and held until reset, and the FSM SHALL return to RUN.
REQ-028 E_md_start_i=1 together with md_done_i=1 in RUN SHALL complete with zero stall.
REQ-029 For each register, stall and bubble SHALL never both be 1 in the same cycle.

Reset
REQ-030 While rst_n=0: state RUN, busy counter 0, md_timeout_o=0, counters 0, and all control outputs 0.
REQ-031 Reset asserted mid-MD_BUSY or mid-FLUSH SHALL abandon the operation with no residual stall after release.

Configuration
REQ-032 With HAZ_PERF_CNT_EN defined: stall_cnt_o SHALL increment on every cycle in which PC_stall_o=1, and flush_cnt_o SHALL increment on entry to FLUSH; both wrap modulo 2^CNT_W.
REQ-033 Without HAZ_PERF_CNT_EN: stall_cnt_o and flush_cnt_o SHALL be tied to 0 and no counter flops SHALL be built.

Verification
REQ-034 Load-use: DD_load_i=1, DD_dstE_i=5, D_rs1_i=5, D_use_rs1_i=1 -> one cycle of PC_stall=F_stall=D_bubble=1; no hazard when DD_dstE_i=0.
REQ-035 Mispredict: pulse E_mispredict_i in RUN -> cycle 0 F_bubble=D_bubble=1; cycle 1 F_bubble=1 only (FLUSH); cycle 2 back in RUN; flush_cnt_o=1.
REQ-036 Divide: E_md_start_i=1, md_done_i=1 after 10 cycles -> md_busy_o=1 for 10 cycles with E_bubble=1; stall_cnt_o=10.
REQ-037 Watchdog: md_done_i never asserted -> md_timeout_o=1 after 64 MD_BUSY cycles, FSM returns to RUN, flag stays set.
REQ-038 Priority: M_dmem_wait_i=1 for 3 cycles during MD_BUSY, together with a load-use hazard -> only the four stalls asserted and state held; MD_BUSY resumes afterwards.
REQ-039 Reset: rst_n=0 mid-MD_BUSY -> all outputs 0 immediately; after release, RUN with no stall.
